fpu_issue_arbiter: RTL and testbench

- Shares one FPU datapath (opa/opb/op_code/mode in; out plus 5 exception flags back) between NREQ requesters.
- Round-robin arbitration; one operation in flight.
- Latches the winner's operands, sequences the FPU with a per-opcode fixed latency, and returns the result tagged with the requester ID over a valid/ready response channel.
- Sits between the issuing engines and the FPU core.

---
 rtl/fpu_issue_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_fpu_issue_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_arbiter.sv
// Round-robin arbiter sharing one FPU datapath among NREQ requesters, one operation in flight.
// Optional macro FPU_ARB_STATS_EN adds saturating stat_ops / stat_busy counters.
module fpu_issue_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned ADD_LAT = 2,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned DIV_LAT = 12
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [32*NREQ-1:0]       req_opa,
    input  logic [32*NREQ-1:0]       req_opb,
    input  logic [2*NREQ-1:0]        req_op,
    input  logic [2*NREQ-1:0]        req_mode,
    output logic [31:0]              fpu_opa,
    output logic [31:0]              fpu_opb,
    output logic [4:0]               fpu_op_code,
    output logic [1:0]               fpu_mode,
    output logic                     fpu_start,
    input  logic [31:0]              fpu_out,
    input  logic [4:0]               fpu_flags,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [$clog2(NREQ)-1:0]  resp_id,
    output logic [31:0]              resp_data,
    output logic [4:0]               resp_flags,
    output logic                     busy
`ifdef FPU_ARB_STATS_EN
    ,
    output logic [15:0]              stat_ops,
    output logic [15:0]              stat_busy
`endif
);

    localparam int unsigned ID_W    = $clog2(NREQ);
    localparam int unsigned AM_LAT  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
    localparam int unsigned MAX_LAT = (AM_LAT > DIV_LAT) ? AM_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic [31:0] opa;
        logic [31:0] opb;
        logic [1:0]  op;
        logic [1:0]  mode;
    } fpu_req_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    fpu_req_t          req_q, req_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fpu_start_q, fpu_start_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_data_q, resp_data_d;
    logic [4:0]        resp_flags_q, resp_flags_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    fpu_req_t          req_arr [NREQ];

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int unsigned off);
        int unsigned s;
        s = (32'(base) + off) % NREQ;
        return ID_W'(s);
    endfunction

    function automatic logic [CNT_W-1:0] lat_of(input logic [1:0] op);
        logic [CNT_W-1:0] l;
        case (op)
            2'b10:   l = CNT_W'(MUL_LAT);
            2'b11:   l = CNT_W'(DIV_LAT);
            default: l = CNT_W'(ADD_LAT);
        endcase
        return l;
    endfunction

    // Unpack the flat request buses into per-requester payloads.
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_arr[i].opa  = req_opa[32*i +: 32];
            req_arr[i].opb  = req_opb[32*i +: 32];
            req_arr[i].op   = req_op[2*i +: 2];
            req_arr[i].mode = req_mode[2*i +: 2];
        end
    end

    // Round-robin search starting just after the last grantee.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!grant_found && req_valid[wrap_idx(rr_ptr_q, k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_idx(rr_ptr_q, k);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == ST_IDLE && grant_found && !rst) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        req_d        = req_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        fpu_start_d  = 1'b0;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_flags_d = resp_flags_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    req_d       = req_arr[grant_idx];
                    id_d        = grant_idx;
                    rr_ptr_d    = grant_idx;
                    fpu_start_d = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = lat_of(req_q.op);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    resp_data_d  = fpu_out;
                    resp_flags_d = fpu_flags;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= ID_W'(NREQ - 1);
            req_q        <= '0;
            id_q         <= '0;
            cnt_q        <= '0;
            fpu_start_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_flags_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            req_q        <= req_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            fpu_start_q  <= fpu_start_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_flags_q <= resp_flags_d;
        end
    end

    assign fpu_opa     = req_q.opa;
    assign fpu_opb     = req_q.opb;
    assign fpu_op_code = {3'b000, req_q.op};
    assign fpu_mode    = req_q.mode;
    assign fpu_start   = fpu_start_q;
    assign resp_valid  = resp_valid_q;
    assign resp_id     = id_q;
    assign resp_data   = resp_data_q;
    assign resp_flags  = resp_flags_q;
    assign busy        = (state_q != ST_IDLE);

`ifdef FPU_ARB_STATS_EN
    logic [15:0] stat_ops_q, stat_ops_d;
    logic [15:0] stat_busy_q, stat_busy_d;

    // Saturating activity counters.
    always_comb begin
        stat_ops_d  = stat_ops_q;
        stat_busy_d = stat_busy_q;
        if (state_q == ST_RESP && resp_ready && stat_ops_q != 16'hFFFF) begin
            stat_ops_d = stat_ops_q + 16'd1;
        end
        if (state_q != ST_IDLE && stat_busy_q != 16'hFFFF) begin
            stat_busy_d = stat_busy_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            stat_ops_q  <= '0;
            stat_busy_q <= '0;
        end else begin
            stat_ops_q  <= stat_ops_d;
            stat_busy_q <= stat_busy_d;
        end
    end

    assign stat_ops  = stat_ops_q;
    assign stat_busy = stat_busy_q;
`endif

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Randomized self-checking bench for fpu_issue_arbiter with a transaction-level reference model.
module tb_fpu_issue_arbiter;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned ADD_LAT = 2;
    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned DIV_LAT = 12;

    logic                 clk_in;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_opa;
    logic [32*NREQ-1:0]   req_opb;
    logic [2*NREQ-1:0]    req_op;
    logic [2*NREQ-1:0]    req_mode;
    logic [31:0]          fpu_opa;
    logic [31:0]          fpu_opb;
    logic [4:0]           fpu_op_code;
    logic [1:0]           fpu_mode;
    logic                 fpu_start;
    logic [31:0]          fpu_out;
    logic [4:0]           fpu_flags;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [1:0]           resp_id;
    logic [31:0]          resp_data;
    logic [4:0]           resp_flags;
    logic                 busy;
`ifdef FPU_ARB_STATS_EN
    logic [15:0]          stat_ops;
    logic [15:0]          stat_busy;
`endif

    fpu_issue_arbiter #(
        .NREQ(NREQ), .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
    ) dut (
        .clk_in(clk_in), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opa(req_opa), .req_opb(req_opb), .req_op(req_op), .req_mode(req_mode),
        .fpu_opa(fpu_opa), .fpu_opb(fpu_opb), .fpu_op_code(fpu_op_code), .fpu_mode(fpu_mode),
        .fpu_start(fpu_start), .fpu_out(fpu_out), .fpu_flags(fpu_flags),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_flags(resp_flags), .busy(busy)
`ifdef FPU_ARB_STATS_EN
        ,
        .stat_ops(stat_ops), .stat_busy(stat_busy)
`endif
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int n_run;
    int n_fail;
    int cyc;

    // Requester side: pending request per requester, held until accepted.
    logic        pend   [NREQ];
    logic [31:0] p_opa  [NREQ];
    logic [31:0] p_opb  [NREQ];
    logic [1:0]  p_op   [NREQ];
    logic [1:0]  p_mode [NREQ];

    // Reference model of the single in-flight transaction.
    logic        active;
    int          acc;
    int          e_lat;
    int          rr;
    int          e_id;
    logic [31:0] e_opa, e_opb, e_data;
    logic [1:0]  e_op, e_mode;
    logic [4:0]  e_flags;
    int          exp_ops, exp_busy;

    // FPU behavioural model controls.
    logic        force_en;
    logic [31:0] force_out;
    logic [4:0]  force_flags;
    int          rem;

    logic [NREQ-1:0] snap_ready;
    logic            snap_start, snap_rv, snap_busy;
    logic [31:0]     snap_data;
    logic [4:0]      snap_flags;
    logic [1:0]      snap_id;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_run++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int lat_of(input logic [1:0] op);
        case (op)
            2'b10:   return int'(MUL_LAT);
            2'b11:   return int'(DIV_LAT);
            default: return int'(ADD_LAT);
        endcase
    endfunction

    function automatic logic [36:0] fres(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] op, input logic [1:0] mode);
        logic [31:0] r;
        logic [4:0]  f;
        r = (a ^ {b[15:0], b[31:16]}) + {28'd0, op, mode};
        f = a[4:0] ^ b[9:5] ^ {1'b0, op, mode};
        return {f, r};
    endfunction

    function automatic int model_grant();
        for (int k = 1; k <= int'(NREQ); k++) begin
            if (pend[(rr + k) % int'(NREQ)]) return (rr + k) % int'(NREQ);
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op, input logic [1:0] mode);
        pend[i] = 1'b1; p_opa[i] = a; p_opb[i] = b; p_op[i] = op; p_mode[i] = mode;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < int'(NREQ); i++) begin
            req_valid[i]        = pend[i];
            req_opa[32*i +: 32] = p_opa[i];
            req_opb[32*i +: 32] = p_opb[i];
            req_op[2*i +: 2]    = p_op[i];
            req_mode[2*i +: 2]  = p_mode[i];
        end
    endtask

    // Fixed-latency FPU: garbage until the result is due, then the result held.
    task automatic fpu_drive();
        if (fpu_start === 1'b1) begin
            rem       = lat_of(fpu_op_code[1:0]);
            fpu_out   = $urandom;
            fpu_flags = 5'($urandom);
        end else if (rem > 0) begin
            rem--;
            if (rem == 0) begin
                if (force_en) {fpu_flags, fpu_out} = {force_flags, force_out};
                else {fpu_flags, fpu_out} = fres(fpu_opa, fpu_opb, fpu_op_code[1:0], fpu_mode);
            end else begin
                fpu_out   = $urandom;
                fpu_flags = 5'($urandom);
            end
        end
    endtask

    // One clock: drive, compare against the model, advance the model, then let the FPU react.
    task automatic tick();
        logic [NREQ-1:0] er;
        logic            erv;
        int              g;
        drive_inputs();
        #1;
        g  = model_grant();
        er = '0;
        if (!active && g >= 0) er[g] = 1'b1;
        erv = active && (cyc >= acc + 1 + e_lat);
        snap_ready = req_ready; snap_start = fpu_start; snap_rv = resp_valid; snap_busy = busy;
        snap_data = resp_data; snap_flags = resp_flags; snap_id = resp_id;
        if (!rst) begin
            chk("req_ready", 64'(req_ready), 64'(er));
            chk("busy", 64'(busy), 64'(active));
            chk("fpu_start", 64'(fpu_start), 64'(active && cyc == acc));
            chk("resp_valid", 64'(resp_valid), 64'(erv));
            if (active) begin
                chk("fpu_opa", 64'(fpu_opa), 64'(e_opa));
                chk("fpu_opb", 64'(fpu_opb), 64'(e_opb));
                chk("fpu_op_code", 64'(fpu_op_code), 64'({3'b000, e_op}));
                chk("fpu_mode", 64'(fpu_mode), 64'(e_mode));
            end
            if (erv) begin
                chk("resp_id", 64'(resp_id), 64'(e_id));
                chk("resp_data", 64'(resp_data), 64'(e_data));
                chk("resp_flags", 64'(resp_flags), 64'(e_flags));
            end
`ifdef FPU_ARB_STATS_EN
            chk("stat_ops", 64'(stat_ops), 64'(exp_ops));
            chk("stat_busy", 64'(stat_busy), 64'(exp_busy));
`endif
        end
        if (rst) begin
            active = 1'b0; rr = int'(NREQ) - 1; exp_ops = 0; exp_busy = 0;
        end else begin
            if (active && exp_busy < 65535) exp_busy++;
            if (erv && resp_ready) begin
                active = 1'b0;
                if (exp_ops < 65535) exp_ops++;
            end else if (!active && g >= 0) begin
                active = 1'b1; acc = cyc + 1; e_id = g; rr = g;
                e_opa = p_opa[g]; e_opb = p_opb[g]; e_op = p_op[g]; e_mode = p_mode[g];
                e_lat = lat_of(p_op[g]);
                if (force_en) {e_flags, e_data} = {force_flags, force_out};
                else {e_flags, e_data} = fres(p_opa[g], p_opb[g], p_op[g], p_mode[g]);
                pend[g] = 1'b0;
            end
        end
        @(posedge clk_in);
        cyc++;
        @(negedge clk_in);
        fpu_drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < int'(NREQ); i++) pend[i] = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Ticks until resp_valid is seen; returns the tick count (bounded).
    task automatic run_until_resp(output int k);
        k = 0;
        while (k < 64) begin
            tick();
            k++;
            if (snap_rv === 1'b1) break;
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int n;
        logic [NREQ-1:0] order [5];
        logic [31:0] d0;
        n_run = 0; n_fail = 0; cyc = 0; rem = 0;
        active = 1'b0; acc = 0; e_lat = 0; rr = int'(NREQ) - 1; e_id = 0;
        e_opa = '0; e_opb = '0; e_op = '0; e_mode = '0; e_data = '0; e_flags = '0;
        exp_ops = 0; exp_busy = 0;
        force_en = 1'b0; force_out = '0; force_flags = '0;
        fpu_out = '0; fpu_flags = '0; resp_ready = 1'b0; rst = 1'b1;
        for (int i = 0; i < int'(NREQ); i++) begin
            pend[i] = 1'b0; p_opa[i] = '0; p_opb[i] = '0; p_op[i] = '0; p_mode[i] = '0;
        end
        @(negedge clk_in);
        do_reset();
        do_reset();

        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_fpu_start", 64'(fpu_start), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fpu_opa", 64'(fpu_opa), 64'd0);
        chk("rst_fpu_opb", 64'(fpu_opb), 64'd0);
        chk("rst_op_code", 64'(fpu_op_code), 64'd0);
        chk("rst_mode", 64'(fpu_mode), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        chk("rst_resp_flags", 64'(resp_flags), 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);

        // Single ADD with a pinned FPU result.
        force_en = 1'b1; force_out = 32'h40400000; force_flags = 5'b00000; resp_ready = 1'b1;
        set_req(0, 32'h3F800000, 32'h40000000, 2'b00, 2'b00);
        tick();
        chk("add_ready", 64'(snap_ready), 64'b0001);
        tick();
        chk("add_start", 64'(snap_start), 64'd1);
        run_until_resp(k);
        chk("add_latency", 64'(k), 64'd3);
        chk("add_data", 64'(snap_data), 64'h40400000);
        chk("add_flags", 64'(snap_flags), 64'd0);
        chk("add_id", 64'(snap_id), 64'd0);
        tick();
        force_en = 1'b0;

        // All requesters continuously valid: strict rotation from requester 0.
        do_reset();
        n = 0;
        for (int t = 0; t < 200 && n < 5; t++) begin
            for (int i = 0; i < int'(NREQ); i++)
                if (!pend[i]) set_req(i, $urandom, $urandom, 2'($urandom_range(0, 2)), 2'($urandom));
            tick();
            if (snap_ready != '0) begin
                order[n] = snap_ready;
                n++;
            end
        end
        chk("rr_count", 64'(n), 64'd5);
        chk("rr_g0", 64'(order[0]), 64'b0001);
        chk("rr_g1", 64'(order[1]), 64'b0010);
        chk("rr_g2", 64'(order[2]), 64'b0100);
        chk("rr_g3", 64'(order[3]), 64'b1000);
        chk("rr_g4", 64'(order[4]), 64'b0001);

        // DIV with back-pressure; a waiting requester must not be accepted early.
        do_reset();
        resp_ready = 1'b0;
        set_req(2, 32'h41200000, 32'h40A00000, 2'b11, 2'b01);
        tick();
        chk("div_ready", 64'(snap_ready), 64'b0100);
        set_req(1, 32'h3F000000, 32'h3E800000, 2'b00, 2'b00);
        run_until_resp(k);
        chk("div_latency", 64'(k), 64'(2 + DIV_LAT));
        d0 = snap_data;
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("stall_ready", 64'(snap_ready), 64'd0);
            chk("stall_valid", 64'(snap_rv), 64'd1);
            chk("stall_data", 64'(snap_data), 64'(d0));
        end
        resp_ready = 1'b1;
        tick();
        chk("hs_ready", 64'(snap_ready), 64'd0);
        tick();
        chk("after_hs_grant", 64'(snap_ready), 64'b0010);

        // Reset in the middle of a DIV wait, then a clean MUL.
        do_reset();
        set_req(0, 32'h40000000, 32'h3F800000, 2'b11, 2'b00);
        tick();
        tick();
        for (int t = 0; t < 3; t++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(3, 32'h40400000, 32'h40800000, 2'b10, 2'b10);
        tick();
        chk("postrst_busy", 64'(snap_busy), 64'd0);
        chk("postrst_valid", 64'(snap_rv), 64'd0);
        chk("postrst_grant", 64'(snap_ready), 64'b1000);
        run_until_resp(k);
        chk("mul_latency", 64'(k), 64'd5);
        chk("mul_id", 64'(snap_id), 64'd3);
        tick();

        // Exception flag passthrough.
        force_en = 1'b1; force_out = 32'h7FC00000; force_flags = 5'b10001;
        set_req(1, 32'h7F800000, 32'h00000000, 2'b10, 2'b00);
        tick();
        run_until_resp(k);
        chk("nan_data", 64'(snap_data), 64'h7FC00000);
        chk("nan_flags", 64'(snap_flags), 64'b10001);
        tick();
        force_en = 1'b0;

`ifdef FPU_ARB_STATS_EN
        do_reset();
        n = 0;
        for (int t = 0; t < 60; t++) begin
            if (!pend[0] && n < 3) begin
                set_req(0, $urandom, $urandom, 2'b00, 2'b00);
                n++;
            end
            tick();
            if (n == 3 && !pend[0] && !active) break;
        end
        chk("stat_ops_3", 64'(stat_ops), 64'd3);
        chk("stat_busy_12", 64'(stat_busy), 64'(3 * (2 + ADD_LAT)));
        force dut.stat_ops_q = 16'hFFFF;
        force dut.stat_busy_q = 16'hFFFF;
        #1;
        release dut.stat_ops_q;
        release dut.stat_busy_q;
        exp_ops = 65535; exp_busy = 65535;
        set_req(2, $urandom, $urandom, 2'b01, 2'b00);
        for (int t = 0; t < 8; t++) tick();
        chk("stat_ops_sat", 64'(stat_ops), 64'hFFFF);
        chk("stat_busy_sat", 64'(stat_busy), 64'hFFFF);
`endif

        // Randomized traffic, back-pressure and occasional reset.
        for (int t = 0; t < 4000; t++) begin
            for (int i = 0; i < int'(NREQ); i++)
                if (!pend[i] && $urandom_range(0, 3) == 0)
                    set_req(i, $urandom, $urandom, 2'($urandom), 2'($urandom));
            resp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
